uart_cmd_decoder: RTL
=====================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 1: command pulse width in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter ERR_CHAR, default 8'h3F ('?'): byte echoed for an unrecognised command.
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); the block uses this one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the upstream uart_rx.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port tx_busy  input  1  high while the downstream uart_tx is transmitting.
REQ-008 SHALL have port btn_run_stop  output  1  run/stop command pulse to the stopwatch control.
REQ-009 SHALL have port btn_clear  output  1  clear command pulse.
REQ-010 SHALL have port btn_mode  output  1  watch/stopwatch mode-toggle pulse.
REQ-011 SHALL have port tx_start  output  1  one-cycle start strobe to uart_tx.
REQ-012 SHALL have port tx_data  output  8  byte for uart_tx, held stable from tx_start until tx_busy falls.
REQ-013 SHALL have port cmd_err  output  1  one-cycle strobe for an unrecognised byte.

Function
REQ-014 SHALL decode only on a cycle where rx_done=1, and SHALL ignore rx_data in all other cycles.
REQ-015 SHALL map 'r'/'R' (8'h72/8'h52) to btn_run_stop, 'c'/'C' (8'h63/8'h43) to btn_clear and 'm'/'M' (8'h6D/8'h4D) to btn_mode.
REQ-016 SHALL assert the mapped output from cycle N+1 through N+PULSE_LEN, where rx_done is sampled in cycle N.
REQ-017 SHALL keep at most one btn_* output high at any time.
REQ-018 SHALL, for any other byte, pulse cmd_err in cycle N+1 and drive no btn_* output.
REQ-019 SHALL, on a valid rx_done during an active pulse, end the current pulse and start the new pulse at N+1 with a full PULSE_LEN count.
REQ-020 SHALL use an 8-bit pulse counter that loads PULSE_LEN-1 and stops at 0 without wrapping.

Reset
REQ-021 SHALL, while reset=1, force all outputs to 0, tx_data to 8'h00, the counter to 0, the echo FSM to IDLE and the pending flag to 0, independent of clk.
REQ-022 SHALL, when reset is asserted during a pulse or an echo, abort it immediately and never complete it after release.
REQ-023 SHALL act on the first rx_done that occurs at least one cycle after reset is released.

Configuration
REQ-024 SHALL compile the echo feature in only when macro UART_CMD_ECHO_EN is defined.
REQ-025 SHALL, with UART_CMD_ECHO_EN defined, use echo FSM IDLE->WAIT->SEND->IDLE with these rules:
- an accepted byte loads a one-deep pending register with rx_data (valid command) or ERR_CHAR (invalid), and sets pending.
- IDLE moves to WAIT when pending=1.
- WAIT moves to SEND when tx_busy=0.
- SEND asserts tx_start for exactly one cycle with tx_data = pending byte, clears pending, then returns to IDLE.
- a new byte arriving while in WAIT overwrites the pending byte (latest wins).
- a new byte arriving in SEND re-sets pending, so a second echo follows.
REQ-026 SHALL, without UART_CMD_ECHO_EN, tie tx_start and tx_data to 0, synthesise no echo FSM or pending register, and leave the command path unchanged.

Verification
REQ-027 Bench SHALL cover: reset, then rx_data=8'h6D with rx_done in cycle N, PULSE_LEN=1 -> btn_mode=1 in cycle N+1 only; other btn_* outputs and cmd_err stay 0.
REQ-028 Bench SHALL cover: PULSE_LEN=4, 'R' -> btn_run_stop high for cycles N+1..N+4; 'c' at N+2 -> btn_run_stop low at N+3 and btn_clear high for N+3..N+6.
REQ-029 Bench SHALL cover: rx_data=8'h41 ('A') -> cmd_err pulse at N+1, no btn_* activity; with echo enabled, tx_start with tx_data=8'h3F.
REQ-030 Bench SHALL cover: echo enabled, tx_busy=1, then 'r' followed by 'm' -> tx_start stays 0 while tx_busy is high; after tx_busy falls, exactly one tx_start with tx_data=8'h6D.
REQ-031 Bench SHALL cover: reset asserted mid-pulse with PULSE_LEN=8 -> all outputs 0 asynchronously; no pulse or tx_start after release until a new rx_done.
REQ-032 Bench SHALL cover: echo disabled, serial 'm' at 104.17 us/bit through uart_rx -> btn_mode pulse, while tx_start stays 0 for the whole run.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns received command bytes into fixed-width button pulses.
// Define UART_CMD_ECHO_EN to echo each accepted byte (or ERR_CHAR) back through uart_tx.
module uart_cmd_decoder #(
    parameter int unsigned PULSE_LEN = 1,
    parameter logic [7:0]  ERR_CHAR  = 8'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       btn_run_stop,
    output logic       btn_clear,
    output logic       btn_mode,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       cmd_err
);

    localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_RUN,
        CMD_CLR,
        CMD_MODE
    } cmd_t;

    cmd_t       rx_cmd;
    logic       cmd_valid;
    logic [2:0] btn_q;
    logic [2:0] btn_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       err_d;

    always_comb begin
        rx_cmd = CMD_NONE;
        case (rx_data)
            8'h72, 8'h52: rx_cmd = CMD_RUN;
            8'h63, 8'h43: rx_cmd = CMD_CLR;
            8'h6D, 8'h4D: rx_cmd = CMD_MODE;
            default:      rx_cmd = CMD_NONE;
        endcase
    end

    assign cmd_valid = (rx_cmd != CMD_NONE);

    // A new valid command replaces any running pulse; btn_q is one-hot or zero.
    always_comb begin
        btn_d = btn_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (rx_done && cmd_valid) begin
            cnt_d = CNT_LOAD;
            case (rx_cmd)
                CMD_RUN:  btn_d = 3'b100;
                CMD_CLR:  btn_d = 3'b010;
                CMD_MODE: btn_d = 3'b001;
                default:  btn_d = 3'b000;
            endcase
        end else begin
            err_d = rx_done;
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                btn_d = 3'b000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q   <= '0;
            cnt_q   <= '0;
            cmd_err <= 1'b0;
        end else begin
            btn_q   <= btn_d;
            cnt_q   <= cnt_d;
            cmd_err <= err_d;
        end
    end

    assign btn_run_stop = btn_q[2];
    assign btn_clear    = btn_q[1];
    assign btn_mode     = btn_q[0];

`ifdef UART_CMD_ECHO_EN
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } echo_state_t;

    echo_state_t state_q;
    echo_state_t state_d;
    logic        pending_q;
    logic        pending_d;
    logic [7:0]  pend_byte_q;
    logic [7:0]  pend_byte_d;

    // A byte accepted in the same cycle as WAIT->SEND goes out directly (latest wins).
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pend_byte_d = pend_byte_q;
        case (state_q)
            IDLE: if (pending_q) state_d = WAIT;
            WAIT: if (!tx_busy) state_d = SEND;
            SEND: begin
                state_d   = IDLE;
                pending_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (rx_done) begin
            pending_d   = 1'b1;
            pend_byte_d = cmd_valid ? rx_data : ERR_CHAR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            pend_byte_q <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pend_byte_q <= pend_byte_d;
            tx_start    <= (state_d == SEND);
            if (state_q == WAIT && state_d == SEND) begin
                tx_data <= pend_byte_d;
            end
        end
    end
`else
    logic [8:0] unused_echo;

    assign unused_echo = {tx_busy, ERR_CHAR};
    assign tx_start    = 1'b0;
    assign tx_data     = '0;
`endif

endmodule
